op_data_sel_encoder: RTL and testbench
======================================

// Module: op_data_sel_encoder
// PURPOSE
//  Sequencer that drives the 2-bit operand-data select code consumed by the operand-data select decoder.
//  - Collects active-low operand requests from 3 operand-data sources.
//  - Grants one source at a time, round-robin.
//  - Drives selectorBits with a valid/ack handshake to the operand datapath.
//  - Holds the code stable for a settle window so the downstream NAND decode output cannot glitch.
// PARAMETERS
//  HOLD_CYCLES     2    cycles selectorBits stays stable after ack before the next grant (0 = no settle window)
//  TIMEOUT_CYCLES  16   max cycles in GRANT without selAck before abort (>=1)
// PORTS
//  clk            in   1  single clock; all state changes on rising edge
//  reset          in   1  synchronous, active-high; dominates all other inputs
//  opRequest_     in   3  active-low level requests; bit i = source i
//  selAck         in   1  datapath accepted current code (1-cycle pulse)
//  selectorBits   out  2  registered code: src0=2'b00, src1=2'b01, src2=2'b10
//  selValid       out  1  selectorBits holds a live grant awaiting ack
//  opGrant_       out  3  active-low one-hot grant, low in GRANT and HOLD only
//  timeoutErr     out  1  1-cycle pulse on grant abort
// BEHAVIOUR
//  Reset values (next edge with reset=1):
//   - state=IDLE, rrPtr=0, selValid=0, opGrant_=3'b111, timeoutErr=0.
//   - selectorBits=2'b00, or 2'b11 with the CONFIGURATION macro defined.
//  IDLE:
//   - If any opRequest_ bit is low, choose the first low bit scanning rrPtr, rrPtr+1, rrPtr+2 (mod 3).
//   - Next edge: state=GRANT, selectorBits=code, selValid=1, opGrant_[i]=0, timeout count=0.
//   - Latency from request low to selValid=1 is 1 cycle.
//   - selAck is ignored in IDLE.
//  GRANT:
//   - selAck=1: next edge selValid=0, state=HOLD, or IDLE if HOLD_CYCLES=0.
//   - Otherwise count++. When count==TIMEOUT_CYCLES-1 with no ack: next edge timeoutErr=1, selValid=0, opGrant_=3'b111, state=IDLE.
//   - selAck arriving on the timeout cycle wins: the grant completes, no timeoutErr.
//  HOLD:
//   - selectorBits and opGrant_ stay unchanged for exactly HOLD_CYCLES cycles.
//   - Then opGrant_=3'b111 and state=IDLE.
//  Round-robin pointer:
//   - On leaving GRANT (ack or timeout), rrPtr = (granted index + 1) mod 3.
//   - Pointer wrap: 2 -> 0.
//  Requests are level-sampled only in IDLE. Withdrawing a request mid-grant does not cancel the grant.
//  A request held low across completion is re-eligible at the next IDLE, behind the other requesters.
//  Code 2'b11 is never a grant code. selectorBits changes only on the IDLE->GRANT edge or on reset (or the park edge, see CONFIGURATION).
//  Reset mid-operation: the current grant is abandoned without timeoutErr and all outputs return to reset values.
// CONFIGURATION
//  OP_DATA_PARK_EN defined:
//   - On every return to IDLE (after HOLD, timeout, or HOLD_CYCLES=0 ack) selectorBits parks at 2'b11, the unused code.
//   - With it, all decoded source selects are inactive while idle.
//   - The reset value is also 2'b11.
//  OP_DATA_PARK_EN undefined:
//   - selectorBits holds the last granted code in IDLE.
//   - The reset value is 2'b00.
// STRUCTURE
//  op_data_pkg holds:
//   - typedef enum logic [1:0] {IDLE, GRANT, HOLD} op_sel_state_t.
//   - Constants SEL_SRC0=2'b00, SEL_SRC1=2'b01, SEL_SRC2=2'b10, SEL_PARK=2'b11, NUM_OP_SRC=3.
//  Sub-module rr_pick3 (combinational):
//   - Inputs: req (active-high, 3 bits) and ptr (2 bits).
//   - Outputs: anyReq and idx (2 bits).
//  The top level holds the FSM, counters and output registers.
// TESTING
//  1. Single requester: reset, then opRequest_=3'b101, selAck at GRANT cycle 3 -> selectorBits=2'b01, selValid=1 one cycle after request; opGrant_=3'b101 for 3+2 cycles; then 3'b111.
//  2. Fairness: opRequest_=3'b000 held, ack every grant -> selectorBits sequence 00,01,10,00; each code held stable through HOLD.
//  3. Timeout: request src2, never ack, TIMEOUT_CYCLES=16 -> timeoutErr pulses exactly once, 16 cycles after selValid rose; rrPtr=0; next grant is src0 if requested.
//  4. Ack on timeout cycle: selAck=1 at count 15 -> no timeoutErr; HOLD entered.
//  5. Mid-op reset: reset=1 during HOLD -> next edge all outputs at reset values; a request held low is regranted starting from src0.
//  6. Park: build with and without OP_DATA_PARK_EN -> in IDLE, selectorBits is 2'b11 with the macro, last code without; 2'b11 never appears while selValid=1.

Source files
------------

// File: rtl/op_data_pkg.sv
// rtl/op_data_pkg.sv - shared types, select codes and helpers for the operand-data select encoder
package op_data_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} op_sel_state_t;

  localparam logic [1:0] SEL_SRC0 = 2'b00;
  localparam logic [1:0] SEL_SRC1 = 2'b01;
  localparam logic [1:0] SEL_SRC2 = 2'b10;
  localparam logic [1:0] SEL_PARK = 2'b11;
  localparam int NUM_OP_SRC = 3;

  // Select code driven for a granted source index; 2'b11 is never produced here.
  function automatic logic [1:0] src_code(input logic [1:0] idx);
    case (idx)
      2'd1:    return SEL_SRC1;
      2'd2:    return SEL_SRC2;
      default: return SEL_SRC0;
    endcase
  endfunction

  // Active-low one-hot grant pattern for a source index.
  function automatic logic [2:0] grant_mask(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b110;
      2'd1:    return 3'b101;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/op_data_sel_encoder_rr_pick3.sv
// rtl/op_data_sel_encoder_rr_pick3.sv - combinational round-robin picker over three requesters
module rr_pick3
  import op_data_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic       anyReq,
  output logic [1:0] idx
);

  int   pos;
  logic found;

  assign anyReq = |req;

  // Scan ptr, ptr+1, ptr+2 (mod 3) and take the first active request.
  always_comb begin
    idx   = 2'd0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_OP_SRC; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_OP_SRC) pos = pos - NUM_OP_SRC;
      if (!found && req[pos[1:0]]) begin
        idx   = pos[1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/op_data_sel_encoder.sv
// rtl/op_data_sel_encoder.sv - round-robin operand-data select sequencer; OP_DATA_PARK_EN parks the code at 2'b11 when idle
module op_data_sel_encoder
  import op_data_pkg::*;
#(
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 16
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opRequest_,
  input  logic       selAck,
  output logic [1:0] selectorBits,
  output logic       selValid,
  output logic [2:0] opGrant_,
  output logic       timeoutErr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 2);

`ifdef OP_DATA_PARK_EN
  localparam bit PARK_EN = 1'b1;
`else
  localparam bit PARK_EN = 1'b0;
`endif

  localparam logic [1:0] RESET_SEL = PARK_EN ? SEL_PARK : SEL_SRC0;

  op_sel_state_t  state;
  logic [1:0]     rr_ptr;
  logic [1:0]     gnt_idx;
  logic [1:0]     pick_idx;
  logic [1:0]     next_ptr;
  logic           any_req;
  logic [CW-1:0]  tmo_cnt;
  logic [HW-1:0]  hold_cnt;

  rr_pick3 u_pick (
    .req    (~opRequest_),
    .ptr    (rr_ptr),
    .anyReq (any_req),
    .idx    (pick_idx)
  );

  // Source after the one just served gets first look next time.
  assign next_ptr = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;

  // Grant FSM: requests are sampled only in IDLE; the code never moves while a grant is live or settling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= 2'd0;
      gnt_idx      <= 2'd0;
      tmo_cnt      <= '0;
      hold_cnt     <= '0;
      selectorBits <= RESET_SEL;
      selValid     <= 1'b0;
      opGrant_     <= 3'b111;
      timeoutErr   <= 1'b0;
    end else begin
      timeoutErr <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state        <= GRANT;
            gnt_idx      <= pick_idx;
            selectorBits <= src_code(pick_idx);
            selValid     <= 1'b1;
            opGrant_     <= grant_mask(pick_idx);
            tmo_cnt      <= '0;
          end
        end
        GRANT: begin
          if (selAck) begin
            // An ack on the last timeout cycle still completes the grant.
            selValid <= 1'b0;
            rr_ptr   <= next_ptr;
            hold_cnt <= '0;
            if (HOLD_CYCLES == 0) begin
              state    <= IDLE;
              opGrant_ <= 3'b111;
              if (PARK_EN) selectorBits <= SEL_PARK;
            end else begin
              state <= HOLD;
            end
          end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            timeoutErr <= 1'b1;
            selValid   <= 1'b0;
            opGrant_   <= 3'b111;
            rr_ptr     <= next_ptr;
            state      <= IDLE;
            if (PARK_EN) selectorBits <= SEL_PARK;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        HOLD: begin
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            state    <= IDLE;
            opGrant_ <= 3'b111;
            if (PARK_EN) selectorBits <= SEL_PARK;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_op_data_sel_encoder.sv
// tb/tb_op_data_sel_encoder.sv - self-checking bench for op_data_sel_encoder with a transaction-level model
module tb_op_data_sel_encoder;

  localparam int HOLD = 2;
  localparam int TMO  = 16;
`ifdef OP_DATA_PARK_EN
  localparam int IDLE_PARK = 1;
`else
  localparam int IDLE_PARK = 0;
`endif
  localparam int RST_CODE = IDLE_PARK ? 3 : 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opRequest_ = 3'b111;
  logic       selAck = 1'b0;
  logic [1:0] selectorBits;
  logic       selValid;
  logic [2:0] opGrant_;
  logic       timeoutErr;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  op_data_sel_encoder #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .opRequest_   (opRequest_),
    .selAck       (selAck),
    .selectorBits (selectorBits),
    .selValid     (selValid),
    .opGrant_     (opGrant_),
    .timeoutErr   (timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: who owns the select lines, whether they acked, how long they waited, how much settle time remains.
  int m_owner = -1;
  int m_acked = 0;
  int m_age = 0;
  int m_hold_left = 0;
  int m_ptr = 0;
  int m_code = RST_CODE;
  int m_err = 0;
  int m_i;

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1; m_acked = 0; m_ptr = 0; m_code = RST_CODE; m_err = 0;
    end else begin
      m_err = 0;
      if (m_owner < 0) begin
        for (int k = 0; k < 3; k++) begin
          m_i = (m_ptr + k) % 3;
          if (m_owner < 0 && opRequest_[m_i] == 1'b0) begin
            m_owner = m_i; m_acked = 0; m_age = 0; m_code = m_i;
          end
        end
      end else if (m_acked == 0) begin
        if (selAck) begin
          m_ptr = (m_owner + 1) % 3;
          if (HOLD == 0) begin
            m_owner = -1;
            if (IDLE_PARK != 0) m_code = 3;
          end else begin
            m_acked = 1; m_hold_left = HOLD;
          end
        end else if (m_age == TMO - 1) begin
          m_err = 1; m_ptr = (m_owner + 1) % 3; m_owner = -1;
          if (IDLE_PARK != 0) m_code = 3;
        end else begin
          m_age = m_age + 1;
        end
      end else begin
        m_hold_left = m_hold_left - 1;
        if (m_hold_left == 0) begin
          m_owner = -1;
          if (IDLE_PARK != 0) m_code = 3;
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model, plus the live-code-is-never-park rule.
  always @(negedge clk) begin
    if (check_en) begin
      chk("sel", int'(selectorBits), m_code);
      chk("valid", int'(selValid), (m_owner >= 0 && m_acked == 0) ? 1 : 0);
      chk("grant", int'(opGrant_), (m_owner >= 0) ? (7 & ~(1 << m_owner)) : 7);
      chk("terr", int'(timeoutErr), m_err);
      if (selValid) chk("live_code_not_park", int'(selectorBits == 2'b11), 0);
    end
  end

  logic [1:0] exp_seq [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
  int n;
  int guard;

  initial begin
    // Reset values
    step(1);
    check_en = 1'b1;
    step(1);
    chk("rst_sel", int'(selectorBits), RST_CODE);
    chk("rst_valid", int'(selValid), 0);
    chk("rst_grant", int'(opGrant_), 7);
    chk("rst_terr", int'(timeoutErr), 0);
    reset = 1'b0;
    step(1);

    // Single requester src1, ack in the third GRANT cycle
    opRequest_ = 3'b101;
    step(1);
    chk("t1_sel", int'(selectorBits), 1);
    chk("t1_valid", int'(selValid), 1);
    chk("t1_grant", int'(opGrant_), 5);
    opRequest_ = 3'b111;
    n = 1;
    step(1); if (opGrant_ == 3'b101) n++;
    step(1); if (opGrant_ == 3'b101) n++;
    selAck = 1'b1;
    step(1);
    selAck = 1'b0;
    guard = 0;
    while (opGrant_ != 3'b111 && guard < 40) begin
      n++; guard++; step(1);
    end
    chk("t1_grant_low_cycles", n, 5);
    chk("t1_idle_sel", int'(selectorBits), IDLE_PARK ? 3 : 1);

    // Fairness: all three request continuously
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    opRequest_ = 3'b000;
    for (int g = 0; g < 4; g++) begin
      guard = 0;
      while (!selValid && guard < 40) begin
        guard++; step(1);
      end
      chk("t2_wait_bound", int'(guard < 40), 1);
      chk("t2_seq", int'(selectorBits), int'(exp_seq[g]));
      selAck = 1'b1;
      step(1);
      selAck = 1'b0;
    end
    opRequest_ = 3'b111;
    step(5);

    // Timeout on src2, with src0 queued behind it
    opRequest_ = 3'b011;
    step(1);
    chk("t3_sel", int'(selectorBits), 2);
    opRequest_ = 3'b010;
    n = 0; guard = 0;
    while (!timeoutErr && guard < 40) begin
      n++; guard++; step(1);
    end
    chk("t3_terr_latency", n, 16);
    chk("t3_valid_dropped", int'(selValid), 0);
    chk("t3_idle_sel", int'(selectorBits), IDLE_PARK ? 3 : 2);
    step(1);
    chk("t3_next_src0", int'(selectorBits), 0);
    chk("t3_next_grant", int'(opGrant_), 6);
    chk("t3_terr_once", int'(timeoutErr), 0);
    opRequest_ = 3'b111;
    selAck = 1'b1;
    step(1);
    selAck = 1'b0;
    step(4);

    // Ack on the final timeout cycle wins
    opRequest_ = 3'b101;
    step(1);
    opRequest_ = 3'b111;
    step(15);
    selAck = 1'b1;
    step(1);
    selAck = 1'b0;
    chk("t4_terr", int'(timeoutErr), 0);
    chk("t4_valid", int'(selValid), 0);
    chk("t4_hold_grant", int'(opGrant_), 5);
    step(4);

    // Reset during HOLD, then regrant from pointer 0
    opRequest_ = 3'b001;
    step(1);
    chk("t5_sel", int'(selectorBits), 2);
    selAck = 1'b1;
    step(1);
    selAck = 1'b0;
    reset = 1'b1;
    step(1);
    chk("t5_rst_sel", int'(selectorBits), RST_CODE);
    chk("t5_rst_grant", int'(opGrant_), 7);
    chk("t5_rst_valid", int'(selValid), 0);
    chk("t5_rst_terr", int'(timeoutErr), 0);
    reset = 1'b0;
    step(1);
    chk("t5_regrant_src1", int'(selectorBits), 1);
    opRequest_ = 3'b111;
    selAck = 1'b1;
    step(1);
    selAck = 1'b0;
    step(5);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
